// File: rtl/alu_op_sequencer.sv
// Command-issuing front end for the 8-bit combinational ALU: accepts one request at a time,
// drives the ALU for a settle window, then returns the captured 16-bit result.
module alu_op_sequencer #(
    parameter int SETTLE_CYCLES = 1,   // legal range 1..15
    parameter int NUM_OPCODES   = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_cmd,
    input  logic [7:0]  req_a,
    input  logic [7:0]  req_b,
    input  logic        req_chain,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic        rsp_err,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [4:0]  alu_command,
    output logic        alu_enable,
    input  logic [15:0] alu_y,
    output logic [15:0] op_count
);

    localparam logic [4:0] CMD_DIV     = 5'd3;
    localparam logic [4:0] CMD_MOD     = 5'd12;
    localparam logic [5:0] NUM_OPC     = 6'(NUM_OPCODES);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        RESP
    } state_t;

    state_t      state_reg;
    logic [3:0]  settle_reg;
    logic [7:0]  last_a_reg;     // only the low byte of the last good result is ever reused
    logic        cmd_legal;
    logic        div_by_zero;

    assign cmd_legal   = ({1'b0, req_cmd} < NUM_OPC);
    assign div_by_zero = ((alu_command == CMD_DIV) || (alu_command == CMD_MOD)) && (alu_b == 8'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            settle_reg  <= 4'd0;
            last_a_reg  <= 8'd0;
            req_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_result  <= 16'd0;
            rsp_err     <= 1'b0;
            alu_a       <= 8'd0;
            alu_b       <= 8'd0;
            alu_command <= 5'd0;
            alu_enable  <= 1'b0;
            op_count    <= 16'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    alu_enable <= 1'b0;
                    rsp_valid  <= 1'b0;
                    if (req_valid && req_ready) begin
                        alu_command <= req_cmd;
                        alu_b       <= req_b;
                        alu_a       <= req_chain ? last_a_reg : req_a;
                        settle_reg  <= 4'd0;
                        req_ready   <= 1'b0;
                        if (cmd_legal) begin
                            alu_enable <= 1'b1;
                            state_reg  <= DRIVE;
                        end else begin
                            // Illegal opcodes never touch the ALU.
                            rsp_valid  <= 1'b1;
                            rsp_result <= 16'd0;
                            rsp_err    <= 1'b1;
                            state_reg  <= RESP;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                DRIVE: begin
                    req_ready <= 1'b0;
                    if (settle_reg == SETTLE_LAST) begin
                        rsp_result <= alu_y;
                        rsp_err    <= div_by_zero;
                        rsp_valid  <= 1'b1;
                        alu_enable <= 1'b0;
                        state_reg  <= RESP;
                    end else begin
                        settle_reg <= settle_reg + 4'd1;
                    end
                end
                RESP: begin
                    alu_enable <= 1'b0;
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state_reg <= IDLE;
                        if (!rsp_err) begin
                            last_a_reg <= rsp_result[7:0];
                        end
                        if (op_count != 16'hFFFF) begin
                            op_count <= op_count + 16'd1;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: two instances (settle 1 and settle 4) share one stimulus bus,
// each paired with a behavioural ALU; results are checked against a transaction-level model.
module tb_alu_op_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    int          sel = 0;
    logic        req_valid_s = 1'b0;
    logic        rsp_ready_s = 1'b0;
    logic [4:0]  req_cmd = 5'd0;
    logic [7:0]  req_a = 8'd0;
    logic [7:0]  req_b = 8'd0;
    logic        req_chain = 1'b0;

    logic        req_ready_w   [2];
    logic        rsp_valid_w   [2];
    logic [15:0] rsp_result_w  [2];
    logic        rsp_err_w     [2];
    logic [7:0]  alu_a_w       [2];
    logic [7:0]  alu_b_w       [2];
    logic [4:0]  alu_command_w [2];
    logic        alu_enable_w  [2];
    logic [15:0] alu_y_w       [2];
    logic [15:0] op_count_w    [2];

    int total = 0;
    int bad = 0;

    // Reference model state per instance
    logic [7:0] last_m [2];
    int         cnt_m  [2];

    // Behavioural ALU: ADD=0 SUB=1 MUL=2 DIV=3 INC=4 DEC=5 MOD=12, others a scramble
    function automatic logic [15:0] alu_fn(input logic [4:0] cmd, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] wa, wb;
        wa = {8'h00, a};
        wb = {8'h00, b};
        case (cmd)
            5'd0:  return wa + wb;
            5'd1:  return wa - wb;
            5'd2:  return wa * wb;
            5'd3:  return (b == 8'd0) ? 16'hFFFF : wa / wb;
            5'd4:  return wa + 16'd1;
            5'd5:  return wa - 16'd1;
            5'd12: return (b == 8'd0) ? 16'hFFFF : wa % wb;
            default: return {a ^ {3'b000, cmd}, ~b};
        endcase
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        alu_op_sequencer #(
            .SETTLE_CYCLES((gi == 0) ? 1 : 4),
            .NUM_OPCODES(24)
        ) dut (
            .clk(clk),
            .rst_n(rst_n),
            .req_valid(req_valid_s && (sel == gi)),
            .req_ready(req_ready_w[gi]),
            .req_cmd(req_cmd),
            .req_a(req_a),
            .req_b(req_b),
            .req_chain(req_chain),
            .rsp_valid(rsp_valid_w[gi]),
            .rsp_ready(rsp_ready_s && (sel == gi)),
            .rsp_result(rsp_result_w[gi]),
            .rsp_err(rsp_err_w[gi]),
            .alu_a(alu_a_w[gi]),
            .alu_b(alu_b_w[gi]),
            .alu_command(alu_command_w[gi]),
            .alu_enable(alu_enable_w[gi]),
            .alu_y(alu_y_w[gi]),
            .op_count(op_count_w[gi])
        );
        // 16'hDEAD stands in for the floating bus while the ALU is disabled
        assign alu_y_w[gi] = alu_enable_w[gi] ? alu_fn(alu_command_w[gi], alu_a_w[gi], alu_b_w[gi]) : 16'hDEAD;
    end

    logic        o_req_ready, o_rsp_valid, o_rsp_err, o_alu_enable;
    logic [15:0] o_rsp_result, o_op_count;
    logic [7:0]  o_alu_a, o_alu_b;
    logic [4:0]  o_alu_command;
    assign o_req_ready   = req_ready_w[sel];
    assign o_rsp_valid   = rsp_valid_w[sel];
    assign o_rsp_err     = rsp_err_w[sel];
    assign o_alu_enable  = alu_enable_w[sel];
    assign o_rsp_result  = rsp_result_w[sel];
    assign o_op_count    = op_count_w[sel];
    assign o_alu_a       = alu_a_w[sel];
    assign o_alu_b       = alu_b_w[sel];
    assign o_alu_command = alu_command_w[sel];

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s inst=%0d observed=%0h expected=%0h", tag, sel, observed, expected);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid_s = 1'b0;
        rsp_ready_s = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", o_req_ready, 0);
        check("rst_rsp_valid", o_rsp_valid, 0);
        check("rst_alu_enable", o_alu_enable, 0);
        check("rst_op_count", o_op_count, 0);
        check("rst_rsp_result", o_rsp_result, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            last_m[i] = 8'd0;
            cnt_m[i]  = 0;
        end
        $display("reset applied");
    endtask

    task automatic do_op(input logic [4:0] cmd, input logic [7:0] a, input logic [7:0] b,
                         input logic chain, input int stall,
                         output logic [15:0] res, output logic err);
        int          settle, k, en_cnt, waits;
        logic        legal, seen, exp_err;
        logic [7:0]  exp_a;
        logic [15:0] exp_res;
        settle  = (sel == 0) ? 1 : 4;
        legal   = (cmd < 5'd24);
        exp_a   = chain ? last_m[sel] : a;
        exp_res = legal ? alu_fn(cmd, exp_a, b) : 16'h0000;
        exp_err = !legal || (((cmd == 5'd3) || (cmd == 5'd12)) && (b == 8'd0));

        @(negedge clk);
        waits = 0;
        while (!o_req_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        check("req_ready_idle", o_req_ready, 1);
        req_cmd = cmd;
        req_a = a;
        req_b = b;
        req_chain = chain;
        req_valid_s = 1'b1;
        @(posedge clk);
        #1;
        req_valid_s = 1'b0;
        req_a = 8'($urandom);
        req_b = 8'($urandom);
        req_cmd = 5'($urandom);

        k = 0;
        en_cnt = 0;
        seen = 1'b0;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            if (o_alu_enable) begin
                en_cnt++;
                check("alu_a", o_alu_a, exp_a);
                check("alu_b", o_alu_b, b);
                check("alu_command", o_alu_command, cmd);
            end
            if (o_rsp_valid) seen = 1'b1;
        end
        check("rsp_latency", k, legal ? settle + 1 : 1);
        check("enable_cycles", en_cnt, legal ? settle : 0);
        res = o_rsp_result;
        err = o_rsp_err;
        check("rsp_result", res, exp_res);
        check("rsp_err", err, exp_err);

        // Backpressure with a competing request that must be ignored
        for (int i = 0; i < stall; i++) begin
            req_valid_s = 1'b1;
            req_cmd = 5'($urandom_range(0, 23));
            @(negedge clk);
            check("stall_rsp_valid", o_rsp_valid, 1);
            check("stall_rsp_result", o_rsp_result, exp_res);
            check("stall_rsp_err", o_rsp_err, exp_err);
            check("stall_req_ready", o_req_ready, 0);
            check("stall_alu_enable", o_alu_enable, 0);
            check("stall_op_count", o_op_count, cnt_m[sel]);
        end
        req_valid_s = 1'b0;
        rsp_ready_s = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready_s = 1'b0;
        if (!exp_err) last_m[sel] = exp_res[7:0];
        if (cnt_m[sel] < 65535) cnt_m[sel]++;
        @(negedge clk);
        check("post_rsp_valid", o_rsp_valid, 0);
        check("post_op_count", o_op_count, cnt_m[sel]);
        check("post_req_ready", o_req_ready, 1);
        $display("op inst=%0d cmd=%0d a=%02h b=%02h chain=%0d stall=%0d -> result=%04h err=%0d (exp %04h/%0d)",
                 sel, cmd, a, b, chain, stall, res, err, exp_res, exp_err);
    endtask

    initial begin
        logic [15:0] res;
        logic        err;
        logic        stray;

        sel = 0;
        apply_reset();

        do_op(5'd0, 8'd200, 8'd100, 1'b0, 0, res, err);
        check("add_result", res, 16'h012C);
        check("add_err", err, 0);
        check("add_op_count", o_op_count, 1);

        apply_reset();
        do_op(5'd3, 8'h10, 8'h00, 1'b0, 0, res, err);
        check("div0_result", res, 16'hFFFF);
        check("div0_err", err, 1);
        do_op(5'd4, 8'h55, 8'h00, 1'b1, 0, res, err);
        check("chain_after_err", res, 16'h0001);

        do_op(5'd24, 8'h12, 8'h34, 1'b0, 1, res, err);
        check("illegal_result", res, 16'h0000);
        check("illegal_err", err, 1);

        do_op(5'd0, 8'd3, 8'd4, 1'b0, 0, res, err);
        check("add34_result", res, 16'h0007);
        do_op(5'd4, 8'hAA, 8'h00, 1'b1, 0, res, err);
        check("chain_alu_a", o_alu_a, 8'h07);
        check("chain_result", res, 16'h0008);

        do_op(5'd1, 8'd5, 8'd7, 1'b0, 0, res, err);
        check("sub_wrap", res, 16'hFFFE);

        do_op(5'd2, 8'hFF, 8'hFF, 1'b0, 5, res, err);
        check("mul_result", res, 16'hFE01);

        // Settle-4 instance, then reset in the middle of DRIVE
        sel = 1;
        do_op(5'd0, 8'd20, 8'd22, 1'b0, 2, res, err);
        check("s4_add", res, 16'h002A);
        @(negedge clk);
        req_cmd = 5'd2;
        req_a = 8'h11;
        req_b = 8'h22;
        req_chain = 1'b0;
        req_valid_s = 1'b1;
        @(posedge clk);
        #1;
        req_valid_s = 1'b0;
        rsp_ready_s = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_enable_before", o_alu_enable, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_alu_enable", o_alu_enable, 0);
        check("abort_rsp_valid", o_rsp_valid, 0);
        check("abort_op_count", o_op_count, 0);
        check("abort_req_ready", o_req_ready, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            last_m[i] = 8'd0;
            cnt_m[i]  = 0;
        end
        stray = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rsp_valid_w[0] || rsp_valid_w[1]) stray = 1'b1;
        end
        rsp_ready_s = 1'b0;
        check("abort_no_response", stray, 0);
        $display("reset during drive done");
        do_op(5'd4, 8'h99, 8'h00, 1'b1, 0, res, err);
        check("abort_chain_zero", res, 16'h0001);

        // Randomized traffic on both instances
        for (int n = 0; n < 160; n++) begin
            logic [4:0] cmd;
            logic [7:0] a, b;
            sel = (n % 4 == 3) ? 1 : 0;
            case ($urandom_range(0, 7))
                0:       cmd = 5'($urandom_range(24, 31));
                1:       cmd = 5'd3;
                2:       cmd = 5'd12;
                default: cmd = 5'($urandom_range(0, 23));
            endcase
            a = 8'($urandom);
            b = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
            do_op(cmd, a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 3), res, err);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
